// File: rtl/spi_engine.sv
// SPI master shift engine: serialises a right-justified 1..32-bit word MSB-first on mosi,
// captures miso into a parallel word, and generates sck in all four CPOL/CPHA modes.
module spi_engine #(
    parameter int unsigned MAX_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      cpol,
    input  logic                      cpha,
    input  logic [4:0]                bits_per_word,
    input  logic [5:0]                div,
    input  logic [MAX_DATA_WIDTH-1:0] data_in,
    output logic [MAX_DATA_WIDTH-1:0] data_out,
    output logic                      busy,
    output logic                      new_data,
    output logic                      sck,
    output logic                      mosi,
    input  logic                      miso
);

    localparam int unsigned W     = MAX_DATA_WIDTH;
    localparam int unsigned NMAX  = (W < 32) ? W : 32;
    localparam logic [5:0]  NMAX6 = 6'(NMAX);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e         state_q, state_d;
    logic           start_q;
    logic           busy_q, busy_d;
    logic           new_data_q, new_data_d;
    logic           sck_q, sck_d;
    logic           mosi_q, mosi_d;
    logic [W-1:0]   data_out_q, data_out_d;
    logic           cpol_l_q, cpol_l_d;
    logic           cpha_l_q, cpha_l_d;
    logic [5:0]     n_q, n_d;
    logic [5:0]     div_l_q, div_l_d;
    logic [W-1:0]   tx_q, tx_d;
    logic [W-1:0]   rx_q, rx_d;
    logic [5:0]     hcnt_q, hcnt_d;
    logic [6:0]     tog_q, tog_d;

    logic [5:0]     n_req, n_cap;
    logic [6:0]     lshift;
    logic [W-1:0]   tx_load;
    logic [6:0]     last_tog;
    logic           sample_edge;

    // Next-state logic: launch detection, half-period timing, shift/sample edges, completion
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        new_data_d = new_data_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        data_out_d = data_out_q;
        cpol_l_d   = cpol_l_q;
        cpha_l_d   = cpha_l_q;
        n_d        = n_q;
        div_l_d    = div_l_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        hcnt_d     = hcnt_q;
        tog_d      = tog_q;

        n_req = {1'b0, bits_per_word} + 6'd1;
        n_cap = (n_req > NMAX6) ? NMAX6 : n_req;
        // Left-align the word so the next bit to send is always the top bit of tx
        lshift  = 7'(W) - {1'b0, n_cap};
        tx_load = data_in << lshift;
        last_tog = {n_q, 1'b0} - 7'd1;
        // Even k samples in CPHA=0, odd k samples in CPHA=1
        sample_edge = (tog_q[0] == cpha_l_q);

        unique case (state_q)
            StIdle: begin
                sck_d = cpol;
                if (start && !start_q) begin
                    state_d    = StShift;
                    busy_d     = 1'b1;
                    new_data_d = 1'b0;
                    hcnt_d     = '0;
                    tog_d      = '0;
                    cpol_l_d   = cpol;
                    cpha_l_d   = cpha;
                    n_d        = n_cap;
                    div_l_d    = div;
                    rx_d       = '0;
                    if (!cpha) begin
                        mosi_d = tx_load[W-1];
                        tx_d   = tx_load << 1;
                    end else begin
                        tx_d   = tx_load;
                    end
                end
            end
            StShift: begin
                if (hcnt_q == div_l_q) begin
                    hcnt_d = '0;
                    sck_d  = ~sck_q;
                    tog_d  = tog_q + 7'd1;
                    if (sample_edge) begin
                        rx_d = (rx_q << 1) | W'(miso);
                    end else if (tog_q != last_tog) begin
                        mosi_d = tx_q[W-1];
                        tx_d   = tx_q << 1;
                    end
                    if (tog_q == last_tog) begin
                        state_d = StDone;
                    end
                end else begin
                    hcnt_d = hcnt_q + 6'd1;
                end
            end
            StDone: begin
                data_out_d = rx_q;
                new_data_d = 1'b1;
                busy_d     = 1'b0;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous reset; a reset mid-transfer discards it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            new_data_q <= 1'b0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            data_out_q <= '0;
            cpol_l_q   <= 1'b0;
            cpha_l_q   <= 1'b0;
            n_q        <= 6'd1;
            div_l_q    <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            hcnt_q     <= '0;
            tog_q      <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start;
            busy_q     <= busy_d;
            new_data_q <= new_data_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            data_out_q <= data_out_d;
            cpol_l_q   <= cpol_l_d;
            cpha_l_q   <= cpha_l_d;
            n_q        <= n_d;
            div_l_q    <= div_l_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            hcnt_q     <= hcnt_d;
            tog_q      <= tog_d;
        end
    end

    assign busy     = busy_q;
    assign new_data = new_data_q;
    assign sck      = sck_q;
    assign mosi     = mosi_q;
    assign data_out = data_out_q;

endmodule

// File: doc/spi_engine.md
# spi_engine

SPI master shift engine driven by the GPMC register map of the BeagleWire SPI example. It serialises a right-justified word of 1–32 bits MSB-first on `mosi` and captures `miso` into a parallel receive word. It generates `sck` in all four CPOL/CPHA modes at a programmable rate. Status flags `busy` and `new_data` are read back through the status register.

## Interface

Parameters:
- MAX_DATA_WIDTH, 32: width of `data_in` and `data_out`; the transfer length is capped at this value.

Ports:
- clk  in  1  engine clock (PLL output); all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level from the setup register; a transfer launches on its 0→1 edge.
- cpol  in  1  `sck` idle level.
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge.
- bits_per_word  in  5  transfer length N = bits_per_word+1 (1..32).
- div  in  6  half-period of `sck` = div+1 clk cycles.
- data_in  in  MAX_DATA_WIDTH  transmit word; bits [N-1:0] are sent, MSB first.
- data_out  out  MAX_DATA_WIDTH  received word, right-justified; bits above N-1 are zero.
- busy  out  1  high while a transfer is in progress.
- new_data  out  1  high after completion; cleared by the next launch or by reset.
- sck  out  1  SPI clock.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.

## Operation

- States:
  - IDLE → SHIFT on a start edge.
  - SHIFT → DONE after 2N `sck` toggles.
  - DONE → IDLE after one cycle.
- Start edge: `start` is registered into start_q. A launch occurs when `start`=1, start_q=0, and the state is IDLE.
- At launch, the engine latches `cpol`, `cpha`, N, `div`, and `data_in[N-1:0]` into shift registers. Input changes during SHIFT are ignored.
- On a launch edge, `busy` goes to 1, `new_data` goes to 0, the half-period counter goes to 0, and the toggle counter goes to 0.
- If `cpha`=0, `mosi` is set to `data_in[N-1]` at the launch edge.
- SHIFT:
  - The half-period counter runs 0..div.
  - On the cycle where the counter equals `div`, `sck` toggles, the counter wraps, and the toggle index k increments (k = 0..2N-1).
- CPHA=0:
  - Toggles with even k are sample edges: `miso` is shifted into the rx register LSB-first, which fills MSB-first order.
  - Toggles with odd k, except k=2N-1, are shift edges: `mosi` takes the next bit.
- CPHA=1:
  - Toggles with even k are shift edges: `mosi` takes the next bit, starting with bit N-1 at k=0.
  - Toggles with odd k are sample edges.
- `miso` is sampled at the same clk edge on which `sck` toggles.
- After toggle 2N-1, `sck` equals the latched `cpol` and the state moves to DONE.
- DONE: `data_out` is loaded with rx zero-extended, `new_data` is set to 1, `busy` is set to 0, and the state returns to IDLE.
- IDLE:
  - `sck` follows the live `cpol` input, registered with one-cycle delay.
  - `mosi` holds its last value.
  - `data_out` holds its last value.
- A start edge while `busy` is ignored; it does not queue. Holding `start` high never retriggers; software must drop it and raise it again.
- Reset (asynchronous, any time including mid-transfer):
  - State goes to IDLE.
  - `busy`, `new_data`, `mosi`, `sck` = 0.
  - `data_out` = 0.
  - start_q = 0.
  - The partial transfer is discarded.
- The first clk edge after reset release with `start`=1 counts as a launch.

## Timing

- Launch latency: `busy`=1 and a valid first `mosi` bit (CPHA=0) appear on the clk edge that samples the start edge.
- First `sck` toggle occurs div+1 cycles after launch.
- `busy` high duration: 2N·(div+1)+1 cycles. `data_out` and `new_data` update on the same edge that `busy` falls.
- `sck` frequency = f_clk / (2·(div+1)). With div=0, `sck` runs at f_clk/2.
- `mosi` changes only on launch or on shift edges. It is stable for at least div+1 cycles around each sample edge.

## Test plan

- Mode 0, N=8, div=0, `data_in`=0xA5, `mosi` looped to `miso`, pulse `start`:
  - `data_out`=0x000000A5.
  - `busy` high for 17 cycles.
  - 8 rising `sck` edges.
  - `sck` idles low.
- Mode 3 (`cpol`=1, `cpha`=1), N=32, div=3, `data_in`=0xDEADBEEF, loopback:
  - `data_out`=0xDEADBEEF.
  - `busy` high for 257 cycles.
  - `sck` idles high.
  - `mosi` changes only on falling `sck` edges.
- N=5 (`bits_per_word`=4), `miso` tied 1, `data_in`=0xFFFFFFFF:
  - `data_out`=0x0000001F.
  - Exactly 10 `sck` toggles.
- Hold `start` high through completion, then raise `start` again while `busy`:
  - Only one transfer occurs.
  - `new_data`=1 remains until `start` is dropped and raised again, which clears it at launch.
- Assert `rst_n`=0 at toggle k=5 of a mode-1 transfer:
  - `busy`, `sck`, `mosi`, `new_data`, `data_out` all go to 0 immediately.
  - A fresh transfer after release completes correctly.
- Change `div`, `cpha`, and `data_in` mid-transfer:
  - No effect on the current transfer; the latched values are used.
